// File: rtl/key_count_pkg.sv
// Shared types and constants for the key_count_seg design.
package key_count_pkg;

  localparam int unsigned NUM_DIGITS = 3;

  typedef logic [3:0] bcd_t;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a}, indexed by digit value.
  // Entries 10..15 blank the digit.
  localparam logic [15:0][7:0] SEG_LUT = {
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg_of(input bcd_t d);
    return SEG_LUT[d];
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces one active-low key and emits a one-cycle
// pulse when the debounced level falls (press). Releases make no pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic press,
  output logic key_state
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync0;
  logic          sync1;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0 <= 1'b1;
      sync1 <= 1'b1;
    end else begin
      sync0 <= key_in;
      sync1 <= sync0;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      key_state <= 1'b1;
      press     <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync1 == key_state) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        key_state <= sync1;
        cnt       <= '0;
        press     <= ~sync1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/top.sv
// Push-button 3-digit BCD up/down counter scanned onto a common-anode
// seven-segment display.
module top
  import key_count_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SCAN_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in1,
  input  logic       key_in2,
  output logic [2:0] sel,
  output logic [7:0] seg
);

  localparam int unsigned SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [1:0]    IDX_LAST  = 2'(NUM_DIGITS - 1);

  logic inc_evt;
  logic dec_evt;
  logic key1_state_unused;
  logic key2_state_unused;

  bcd_t [NUM_DIGITS-1:0] digits;
  bcd_t [NUM_DIGITS-1:0] digits_nxt;
  logic                  ripple;

  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in1),
    .press     (inc_evt),
    .key_state (key1_state_unused)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_dec (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in2),
    .press     (dec_evt),
    .key_state (key2_state_unused)
  );

  // Next count: ripple a decimal carry/borrow from the units digit upward.
  always_comb begin
    digits_nxt = digits;
    ripple     = 1'b1;
    if (inc_evt && !dec_evt) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (ripple) begin
          if (digits[i] == 4'd9) begin
            digits_nxt[i] = '0;
          end else begin
            digits_nxt[i] = digits[i] + 4'd1;
            ripple        = 1'b0;
          end
        end
      end
    end else if (dec_evt && !inc_evt) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (ripple) begin
          if (digits[i] == 4'd0) begin
            digits_nxt[i] = 4'd9;
          end else begin
            digits_nxt[i] = digits[i] - 4'd1;
            ripple        = 1'b0;
          end
        end
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) digits <= '0;
    else     digits <= digits_nxt;
  end

  // Scan timer and digit index; each digit is held SCAN_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? 2'd0 : idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // sel and seg are registered together from the same index so they always agree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel <= '1;
      seg <= '1;
    end else begin
      sel <= ~(3'b001 << idx);
      seg <= seg_of(digits[idx]);
    end
  end

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: table of key actions with expected counts,
// scoreboard of expected display contents, plus reset corner sequences.
module tb_top;

  localparam int unsigned DEB  = 4;
  localparam int unsigned SCAN = 8;

  localparam int OP_INC  = 0;
  localparam int OP_DEC  = 1;
  localparam int OP_BOTH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_in1 = 1'b1;
  logic       key_in2 = 1'b1;
  logic [2:0] sel;
  logic [7:0] seg;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int op;
    int low;
    int exp;
  } vec_t;

  vec_t vecs[21];
  int   exp_q[$];

  int  both_pulses = 0;
  int  split_pulses = 0;
  bit  watch_both = 1'b0;

  top #(.DEBOUNCE_CYCLES(DEB), .SCAN_CYCLES(SCAN)) dut (
    .clk     (clk),
    .rst     (rst),
    .key_in1 (key_in1),
    .key_in2 (key_in2),
    .sel     (sel),
    .seg     (seg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (watch_both) begin
      if (dut.inc_evt && dut.dec_evt) both_pulses++;
      if (dut.inc_evt != dut.dec_evt) split_pulses++;
    end
  end

  function automatic logic [7:0] ref_seg(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic act(input int op, input int low);
    @(negedge clk);
    key_in1 = (op == OP_DEC);
    key_in2 = (op == OP_INC);
    repeat (low) @(negedge clk);
    key_in1 = 1'b1;
    key_in2 = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  // Grab the segment pattern shown for each digit during one scan pass.
  task automatic capture(output logic [7:0] s0, output logic [7:0] s1,
                         output logic [7:0] s2, output bit ok);
    bit g0 = 0, g1 = 0, g2 = 0;
    s0 = 'x; s1 = 'x; s2 = 'x;
    for (int i = 0; i < 200 && !(g0 && g1 && g2); i++) begin
      @(negedge clk);
      case (sel)
        3'b110: begin s0 = seg; g0 = 1; end
        3'b101: begin s1 = seg; g1 = 1; end
        3'b011: begin s2 = seg; g2 = 1; end
        default: ;
      endcase
    end
    ok = g0 && g1 && g2;
  endtask

  // Pop the next expected count and compare all three digits on the display.
  task automatic check_display(input string tag);
    logic [7:0] s0, s1, s2;
    bit ok;
    int e;
    capture(s0, s1, s2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s scan_timeout: got no full scan expected one within 200 cycles", tag);
    end
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard_empty: got empty queue expected an entry", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_units"},    int'(s0), int'(ref_seg(e % 10)));
    chk({tag, "_tens"},     int'(s1), int'(ref_seg((e / 10) % 10)));
    chk({tag, "_hundreds"}, int'(s2), int'(ref_seg(e / 100)));
  endtask

  initial begin
    vecs[0]  = '{OP_INC, 9, 1};
    vecs[1]  = '{OP_INC, 9, 2};
    vecs[2]  = '{OP_DEC, 9, 1};
    vecs[3]  = '{OP_DEC, 9, 0};
    vecs[4]  = '{OP_DEC, 9, 999};
    vecs[5]  = '{OP_BOTH, 9, 999};
    vecs[6]  = '{OP_BOTH, 9, 999};
    vecs[7]  = '{OP_INC, 2, 999};
    vecs[8]  = '{OP_INC, 100, 0};
    for (int k = 1; k <= 9; k++) vecs[8 + k] = '{OP_INC, 9, k};
    vecs[18] = '{OP_INC, 9, 10};
    vecs[19] = '{OP_DEC, 100, 9};
    vecs[20] = '{OP_DEC, 2, 9};

    // Reset held: display blank.
    repeat (10) @(negedge clk);
    chk("reset_sel", int'(sel), 32'h7);
    chk("reset_seg", int'(seg), 32'hFF);
    rst = 1'b0;
    @(negedge clk);
    chk("first_sel", int'(sel), 32'h6);
    chk("first_seg", int'(seg), 32'hC0);
    exp_q.push_back(0);
    check_display("post_reset");

    foreach (vecs[i]) begin
      watch_both = (vecs[i].op == OP_BOTH);
      exp_q.push_back(vecs[i].exp);
      act(vecs[i].op, vecs[i].low);
      watch_both = 1'b0;
      check_display($sformatf("vec%0d", i));
    end
    chk("both_pulses", both_pulses, 2);
    chk("split_pulses", split_pulses, 0);

    // Reset while key_in1 is held: blank at once, then one press after release.
    @(negedge clk);
    key_in1 = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_sel", int'(sel), 32'h7);
    chk("midrst_seg", int'(seg), 32'hFF);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_first_seg", int'(seg), 32'hC0);
    exp_q.push_back(1);
    repeat (20) @(negedge clk);
    check_display("held_through_reset");
    key_in1 = 1'b1;
    exp_q.push_back(1);
    repeat (20) @(negedge clk);
    check_display("after_release");

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
